// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared types and helpers for the BRAM port arbiter and other
//               crossbar ports that need a cyclic one-hot picker.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    // Widest requester index supported (NUM_REQ up to 8).
    localparam int ARB_IDX_W   = 3;
    localparam int ARB_MAX_REQ = 8;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    // One stage of the response pipe: did a grant happen, and to whom.
    typedef struct packed {
        logic                 valid;
        logic [ARB_IDX_W-1:0] idx;
    } rsp_entry_t;

    // Cyclic priority pick over the low n bits of req, starting at ptr.
    function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [ARB_IDX_W-1:0]   ptr,
        input int unsigned            n
    );
        logic [ARB_MAX_REQ-1:0] gnt;
        logic                   found;
        int unsigned            k;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
            if (i < n) begin
                k = (32'(ptr) + i) % n;
                if (!found && req[k[ARB_IDX_W-1:0]]) begin
                    gnt[k[ARB_IDX_W-1:0]] = 1'b1;
                    found                 = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_onehot.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_onehot
// Description : Combinational cyclic priority picker. Grants the first set
//               request at or after ptr_i, wrapping at N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_onehot #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    int               w_k;
    logic [IDX_W-1:0] w_k_idx;
    logic             w_found;

    // Walk the requesters in cyclic order from ptr_i and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_k     = 0;
        w_k_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_k     = (int'(ptr_i) + i) % N;
            w_k_idx = IDX_W'(w_k);
            if (!w_found && req_i[w_k_idx]) begin
                gnt_o[w_k_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one single-ported BRAM between
//               NUM_REQ requesters, with bounded lock and fixed-latency
//               rvalid return.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ-1:0]                 lock_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    output logic [NUM_REQ-1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    output logic                               bram_en_o,
    output logic [DATA_WIDTH/8-1:0]            bram_we_o,
    output logic [ADDR_WIDTH-1:0]              bram_addr_o,
    output logic [DATA_WIDTH-1:0]              bram_wdata_o,
    input  logic [DATA_WIDTH-1:0]              bram_rdata_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] ST_UNLOCKED = UNLOCKED;
    localparam logic [0:0] ST_LOCKED   = LOCKED;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rsp_entry_t       pipe_q [READ_LATENCY];

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic               w_owner_beat;

    rr_pick_onehot #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (w_rr_gnt)
    );

    // Grant: locked owner wins while it requests, otherwise round-robin.
    // Held at zero during reset so nothing reaches the BRAM.
    always_comb begin
        w_owner_beat = (state_q == ST_LOCKED) && req_i[owner_q];
        w_gnt        = '0;
        if (!rst_i) begin
            if (w_owner_beat) begin
                w_gnt[owner_q] = 1'b1;
            end else begin
                w_gnt = w_rr_gnt;
            end
        end
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = IDX_W'(i);
            end
        end
        w_gnt_any = |w_gnt;
    end

    // Next arbitration state: pointer advance, lock entry, lock exit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (w_gnt_any) begin
            ptr_d = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        end
        if (w_owner_beat) begin
            // The beat that brings the count to MAX_LOCK is the last one;
            // a lock request on that beat is dropped.
            cnt_d = cnt_q + CNT_W'(1);
            if (!lock_i[owner_q] || (cnt_q == CNT_W'(MAX_LOCK - 1))) begin
                state_d = ST_UNLOCKED;
                cnt_d   = '0;
            end
        end else begin
            // Idle owner cycles fall back to plain round-robin, which may
            // start a fresh lock for whoever gets this grant.
            state_d = ST_UNLOCKED;
            cnt_d   = '0;
            if (w_gnt_any && lock_i[w_gnt_idx] && (MAX_LOCK > 1)) begin
                state_d = ST_LOCKED;
                owner_d = w_gnt_idx;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_UNLOCKED;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response pipe tracks who was granted, READ_LATENCY cycles deep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: w_gnt_any, idx: ARB_IDX_W'(w_gnt_idx)};
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Decode the pipe tail into a one-hot response valid.
    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_o[i] = pipe_q[READ_LATENCY-1].valid &&
                          (pipe_q[READ_LATENCY-1].idx == ARB_IDX_W'(i));
        end
    end

    // Steer the granted requester's fields onto the BRAM port.
    always_comb begin
        bram_we_o    = '0;
        bram_addr_o  = '0;
        bram_wdata_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                bram_we_o    = we_i[i*STRB_W +: STRB_W];
                bram_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                bram_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt_o     = w_gnt;
    assign bram_en_o = w_gnt_any;
    assign rdata_o   = bram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. Two instances
//               (READ_LATENCY 1 and 3) share stimulus; a behavioural model
//               predicts grants, responses and read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int ML = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req, lock;
    logic [N*SW-1:0] we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;

    logic [N-1:0]  gnt1, rvalid1, gnt3, rvalid3;
    logic [DW-1:0] rdata1, rdata3, bwdata1, bwdata3, brd1, brd3;
    logic          en1, en3;
    logic [SW-1:0] bwe1, bwe3;
    logic [AW-1:0] baddr1, baddr3;

    bram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .READ_LATENCY(1), .MAX_LOCK(ML)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .bram_en_o(en1), .bram_we_o(bwe1),
        .bram_addr_o(baddr1), .bram_wdata_o(bwdata1), .bram_rdata_i(brd1));

    bram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .READ_LATENCY(3), .MAX_LOCK(ML)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rvalid3),
        .rdata_o(rdata3), .bram_en_o(en3), .bram_we_o(bwe3),
        .bram_addr_o(baddr3), .bram_wdata_o(bwdata3), .bram_rdata_i(brd3));

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_0000 ^ (64'(i) * 64'h0001_0001_0001_0001);
    endfunction

    // BRAM behavioural model: 1-cycle and 3-cycle read paths, preload in reset.
    logic [63:0] mem [0:255];
    logic [63:0] rd3_0, rd3_1, rd3_2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (en1) begin
            for (int b = 0; b < SW; b++)
                if (bwe1[b]) mem[baddr1[10:3]][8*b +: 8] <= bwdata1[8*b +: 8];
        end
        brd1  <= mem[baddr1[10:3]];
        rd3_0 <= mem[baddr3[10:3]];
        rd3_1 <= rd3_0;
        rd3_2 <= rd3_1;
    end
    assign brd3 = rd3_2;

    // Reference model state.
    typedef struct { bit v; int idx; bit rd; logic [63:0] data; } hent_t;
    hent_t       hist [8];
    logic [63:0] refmem [0:255];
    int          m_ptr, m_owner, m_cnt, m_last, cyc;
    bit          m_locked;
    int          n_cmp, n_err;

    logic [2:0]  o_gnt, o_rv1, o_rv3;
    logic [63:0] o_rd1;
    logic [15:0] o_addr;
    logic [7:0]  o_we;
    logic        o_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pick_model(output int g);
        g = -1;
        if (m_locked && req[m_owner]) g = m_owner;
        else begin
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (g < 0 && req[k]) g = k;
            end
        end
    endtask

    task automatic model_advance(input int g);
        if (m_locked && g == m_owner) begin
            m_cnt++;
            if (!lock[g] || m_cnt == ML) begin m_locked = 0; m_cnt = 0; end
        end else begin
            m_locked = 0; m_cnt = 0;
            if (g >= 0 && lock[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
        end
        if (g >= 0) m_ptr = (g + 1) % N;
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic cycle();
        int g; hent_t e1, e3; logic [2:0] eg; logic [7:0] gw; int wi;
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) hist[i].v = 0;
            for (int i = 0; i < 256; i++) refmem[i] = pat(i);
            m_ptr = 0; m_locked = 0; m_cnt = 0; m_owner = 0;
            g = -1;
        end else pick_model(g);
        eg = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("gnt", 64'(gnt1), 64'(eg));
        chk("gnt_rl3", 64'(gnt3), 64'(eg));
        chk("bram_en", 64'(en1), 64'(g >= 0));
        if (g >= 0) begin
            gw = we[g*SW +: SW];
            chk("bram_addr", 64'(baddr1), 64'(addr[g*AW +: AW]));
            chk("bram_we", 64'(bwe1), 64'(gw));
            if (gw != 0) chk("bram_wdata", bwdata1, wdata[g*DW +: DW]);
        end else begin
            gw = 8'h00;
            chk("bram_we_idle", 64'(bwe1), 64'd0);
        end
        e1 = hist[(cyc + 7) % 8];
        e3 = hist[(cyc + 5) % 8];
        chk("rvalid_rl1", 64'(rvalid1), e1.v ? 64'(1 << e1.idx) : 64'd0);
        chk("rvalid_rl3", 64'(rvalid3), e3.v ? 64'(1 << e3.idx) : 64'd0);
        if (e1.v && e1.rd) chk("rdata_rl1", rdata1, e1.data);
        if (e3.v && e3.rd) chk("rdata_rl3", rdata3, e3.data);
        hist[cyc % 8].v = (g >= 0);
        if (g >= 0) begin
            wi = int'(addr[g*AW + 3 +: 8]);
            hist[cyc % 8].idx  = g;
            hist[cyc % 8].rd   = (gw == 0);
            hist[cyc % 8].data = refmem[wi];
            for (int b = 0; b < SW; b++)
                if (gw[b]) refmem[wi][8*b +: 8] = wdata[g*DW + 8*b +: 8];
        end
        o_gnt = gnt1; o_rv1 = rvalid1; o_rv3 = rvalid3; o_rd1 = rdata1;
        o_addr = baddr1; o_we = bwe1; o_en = en1;
        if (!rst) model_advance(g);
        m_last = g;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct { logic [2:0] req; logic [2:0] exp; } vec_t;
    vec_t tbl [10];

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; m_last = -1;
        m_ptr = 0; m_locked = 0; m_cnt = 0; m_owner = 0;
        for (int i = 0; i < 8; i++) hist[i].v = 0;
        tbl[0] = '{3'b111, 3'b001}; tbl[1] = '{3'b111, 3'b010};
        tbl[2] = '{3'b111, 3'b100}; tbl[3] = '{3'b111, 3'b001};
        tbl[4] = '{3'b111, 3'b010}; tbl[5] = '{3'b111, 3'b100};
        tbl[6] = '{3'b110, 3'b010}; tbl[7] = '{3'b001, 3'b001};
        tbl[8] = '{3'b000, 3'b000}; tbl[9] = '{3'b101, 3'b100};

        // Reset with all requesters asking: nothing may be granted.
        req = 3'b111; lock = '0; we = '0; wdata = '0;
        addr = {16'h0030, 16'h0020, 16'h0010};
        do_reset();
        chk("reset_gnt", 64'(o_gnt), 64'd0);
        chk("reset_en", 64'(o_en), 64'd0);
        chk("reset_rvalid", 64'(o_rv3), 64'd0);

        // Single read.
        req = 3'b001; addr[15:0] = 16'h0010;
        cycle();
        chk("single_gnt", 64'(o_gnt), 64'h1);
        chk("single_en", 64'(o_en), 64'h1);
        chk("single_addr", 64'(o_addr), 64'h10);
        req = 3'b000;
        cycle();
        chk("single_rvalid", 64'(o_rv1), 64'h1);
        chk("single_rdata", o_rd1, pat(2));

        // Write ack, then readback.
        req = 3'b001; we[7:0] = 8'hFF; addr[15:0] = 16'h0018;
        wdata[63:0] = 64'hDEADBEEF_CAFEF00D;
        cycle();
        chk("write_we", 64'(o_we), 64'hFF);
        req = 3'b000; we[7:0] = 8'h00;
        cycle();
        chk("write_rvalid", 64'(o_rv1), 64'h1);
        req = 3'b001;
        cycle();
        req = 3'b000;
        cycle();
        chk("readback", o_rd1, 64'hDEADBEEF_CAFEF00D);
        repeat (3) cycle();

        // Contention and pointer wrap table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            cycle();
            chk($sformatf("tbl%0d_gnt", i), 64'(o_gnt), 64'(tbl[i].exp));
        end
        req = 3'b000;
        repeat (3) cycle();

        // Lock bounded by MAX_LOCK.
        do_reset();
        req = 3'b111; lock = 3'b010;
        for (int c = 0; c < 20; c++) begin
            logic [2:0] ex;
            ex = (c == 0) ? 3'b001 : (c <= 16) ? 3'b010 : (c == 17) ? 3'b100 :
                 (c == 18) ? 3'b001 : 3'b010;
            cycle();
            chk($sformatf("lock%0d_gnt", c), 64'(o_gnt), 64'(ex));
        end

        // Lock released by one idle owner cycle.
        do_reset();
        req = 3'b111; lock = 3'b010;
        cycle(); cycle(); cycle();
        chk("idle_locked_gnt", 64'(o_gnt), 64'h2);
        req = 3'b101;
        cycle();
        chk("idle_release_gnt", 64'(o_gnt), 64'h4);
        req = 3'b111; lock = 3'b000;
        cycle();
        chk("idle_after_gnt", 64'(o_gnt), 64'h1);
        req = 3'b000;
        repeat (3) cycle();

        // Reset while a READ_LATENCY=3 read is in flight.
        req = 3'b001; addr[15:0] = 16'h0028;
        cycle();
        req = 3'b000;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk($sformatf("midrst_rv3_%0d", c), 64'(o_rv3), 64'd0);
        end
        req = 3'b111;
        cycle();
        chk("midrst_first_gnt", 64'(o_gnt), 64'h1);
        req = 3'b000;
        repeat (3) cycle();

        // Randomized traffic against the model.
        for (int t = 0; t < 500; t++) begin
            for (int r = 0; r < N; r++) begin
                if (m_last == r || !req[r]) begin
                    req[r] = ($urandom_range(0, 99) < 60);
                    we[r*SW +: SW] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
                    addr[r*AW +: AW] = {8'h00, 5'($urandom), 3'b000};
                    wdata[r*DW +: DW] = {$urandom, $urandom};
                end else if ($urandom_range(0, 99) < 5) begin
                    req[r] = 1'b0;
                end
                lock[r] = ($urandom_range(0, 99) < 40);
            end
            cycle();
        end
        req = '0; lock = '0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one single-ported BRAM (en/we/addr/wdata/rdata, fixed read latency) between up to NUM_REQ requesters, e.g. the AXI-to-BRAM bridge and the debug-module host port on the boot or JTAG shared memory. Each requester gets a grant/rvalid handshake. A bounded lock lets a requester hold the port for back-to-back beats. Sits between the requesters and the BRAM macro in the clk_i domain.

## Interface
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_WIDTH, 16: BRAM byte-address width.
- DATA_WIDTH, 64: data width; strobe width is DATA_WIDTH/8.
- READ_LATENCY, 1: BRAM cycles from en to valid rdata (1..3).
- MAX_LOCK, 16: maximum consecutive grants to one locked requester.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NUM_REQ  per-requester access request.
- lock_i  in  NUM_REQ  keep grant for the next beat.
- we_i  in  NUM_REQ×DATA_WIDTH/8  byte write strobes; all-zero means a read.
- addr_i  in  NUM_REQ×ADDR_WIDTH  byte address.
- wdata_i  in  NUM_REQ×DATA_WIDTH  write data.
- gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted request.
- rvalid_o  out  NUM_REQ  one-hot response valid, for both reads and writes.
- rdata_o  out  DATA_WIDTH  read data, valid only with rvalid_o.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  DATA_WIDTH/8  BRAM strobes.
- bram_addr_o  out  ADDR_WIDTH  BRAM address.
- bram_wdata_o  out  DATA_WIDTH  BRAM write data.
- bram_rdata_i  in  DATA_WIDTH  BRAM read data.

## Operation
- Arbitration state:
  - Round-robin pointer ptr_q (index of the highest-priority requester).
  - lock_owner_q, with a locked flag.
  - lock_cnt_q (counts beats granted under lock).
- States:
  - UNLOCKED: grant the first requesting index at or after ptr_q, searching cyclically.
    - After a grant to k, ptr_q becomes (k+1) mod NUM_REQ.
    - If lock_i[k] is high during that grant: go to LOCKED, set lock_owner_q=k and lock_cnt_q=1.
  - LOCKED: grant lock_owner_q whenever req_i[owner] is high. Others wait. Each granted beat increments lock_cnt_q.
- Leaving LOCKED (return to UNLOCKED) happens on any of:
  - A granted beat with lock_i[owner] low.
  - req_i[owner] low for one cycle. The idle cycle is given to normal round-robin.
  - lock_cnt_q reaching MAX_LOCK. That beat is granted, then the lock is forcibly released and ptr_q moves past the owner.
- Exactly one grant per cycle at most. bram_en_o = |gnt_o. BRAM fields are muxed from the granted requester.
- Response pipeline: a READ_LATENCY-deep shift register of {valid, owner index}. rvalid_o[idx] pulses exactly READ_LATENCY cycles after the grant. rdata_o = bram_rdata_i, unregistered.
- Requesters hold req/we/addr/wdata stable until granted. Deasserting req before grant is legal; no grant results.

## Timing
- Throughput: one access per cycle, back-to-back across requesters. No bubbles.
- Latency: grant 0 cycles, response READ_LATENCY cycles. A write's rvalid follows the same latency.
- Reset (asynchronous assert, synchronous release):
  - ptr_q=0, UNLOCKED, lock_cnt_q=0, pipeline cleared.
  - gnt_o, rvalid_o, bram_en_o and bram_we_o all 0.
  - In-flight responses are dropped.
- Simultaneous requests: priority is cyclic from ptr_q.
- Pointer wrap: ptr_q=NUM_REQ-1 with requester 0 requesting grants 0 if NUM_REQ-1 is idle.
- Lock timing: a lock asserted on the same cycle as MAX_LOCK expiry is ignored for one arbitration round.
- lock_i on a non-owner in LOCKED: ignored.
- ADDR_WIDTH and DATA_WIDTH are passed through unchanged. No address translation.

## Structure
- Shared package bram_arb_pkg:
  - arb_state_e {UNLOCKED, LOCKED}.
  - Response-pipe entry struct {valid, idx[$clog2(NUM_REQ)-1:0]}.
  - Function rr_pick(req, ptr) returning a one-hot vector.
- Sub-module rr_pick_onehot: the combinational cyclic priority picker, reusable by other crossbar ports.
- Top: state/counter registers, request mux and response shift register.

## Test plan
- Single read: req_i=3'b001, addr 'h10, READ_LATENCY=1. Expect gnt_o=001 at cycle 0, bram_en_o=1, bram_addr_o='h10. At cycle 1, rvalid_o=001 with rdata_o equal to the preloaded value.
- Contention: req_i=3'b111 held for 6 cycles, ptr_q=0. Grants go 001,010,100,001,010,100. rvalid_o mirrors the sequence delayed by 1.
- Lock: requester 1 asserts lock_i with req for 20 cycles while 0 and 2 request, MAX_LOCK=16. Requester 1 receives 16 consecutive grants, then requester 2 is granted.
- Lock release by idle: owner drops req for one cycle. Next grant goes by round-robin to another waiting requester.
- Write ack: we_i=8'hFF, wdata 'hDEADBEEF_CAFEF00D. bram_we_o=8'hFF, rvalid_o pulses after READ_LATENCY, and a readback returns the same value.
- Reset mid-operation: assert rst_i while a read is in flight with READ_LATENCY=3. rvalid_o never pulses. After release, ptr_q=0 and the first grant goes to requester 0.
